// File: rtl/zx_bus_pkg.sv
// Shared types and defaults for the ZX-bus I/O master.
// Bus timing constants used by the RTL and by test rigs.
`timescale 1ns/1ps
package zx_bus_pkg;

    localparam int ZX_ACC_W    = 6;
    localparam int ZX_ACC_STEP = 7;
    localparam int ZX_WAIT_MAX = 255;
    localparam int Z80_CLK_HZ  = 3_500_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } zx_state_e;

endpackage

// File: rtl/tstate_tick.sv
// Phase accumulator producing the average 3.5 MHz T-state tick
// from clk32, plus a free-running bus clock from its MSB.
`timescale 1ns/1ps
module tstate_tick #(
    parameter int ACC_W    = 6,
    parameter int ACC_STEP = 7
) (
    input  logic clk32,
    input  logic rst_n,
    output logic o_tick,
    output logic o_tclk
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(ACC_STEP);
    assign o_tick = w_sum[ACC_W];
    assign o_tclk = r_acc[ACC_W-1];

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/zxbus_io_master.sv
// ZX-bus IN/OUT cycle initiator: turns a single-word request into
// T1/T2/TW/T3 bus cycles paced by the T-state tick.
`timescale 1ns/1ps
module zxbus_io_master
    import zx_bus_pkg::*;
#(
    parameter int ACC_W    = ZX_ACC_W,
    parameter int ACC_STEP = ZX_ACC_STEP,
    parameter int WAIT_MAX = ZX_WAIT_MAX
) (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_claimed,
    output logic        rsp_timeout,
    output logic        tclk,
    output logic [15:0] a,
    inout  wire  [7:0]  d,
    output logic        n_iorq,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_m1,
    output logic        n_mreq,
    input  logic        n_wait,
    input  logic        n_iorqge
);

    localparam logic [7:0] W_MAX = 8'(WAIT_MAX);

    zx_state_e   r_state;
    logic        r_ready;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [15:0] r_a;
    logic        r_d_oe;
    logic        r_iorq_n;
    logic        r_rd_n;
    logic        r_wr_n;
    logic [7:0]  r_wcnt;
    logic        r_to;
    logic        r_rsp_valid;
    logic [7:0]  r_rdata;
    logic        r_claimed;
    logic        r_timeout;
    logic [1:0]  r_wait_s;
    logic [1:0]  r_iorqge_s;
    logic        w_tick;
    logic        w_tclk;

    tstate_tick #(
        .ACC_W    (ACC_W),
        .ACC_STEP (ACC_STEP)
    ) u_tick (
        .clk32  (clk32),
        .rst_n  (rst_n),
        .o_tick (w_tick),
        .o_tclk (w_tclk)
    );

    assign tclk        = w_tclk;
    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_claimed = r_claimed;
    assign rsp_timeout = r_timeout;
    assign a           = r_a;
    assign n_iorq      = r_iorq_n;
    assign n_rd        = r_rd_n;
    assign n_wr        = r_wr_n;
    assign n_m1        = 1'b1;
    assign n_mreq      = 1'b1;
    assign d           = r_d_oe ? r_wdata : 8'hzz;

    // Card-side inputs are asynchronous to clk32.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_s   <= 2'b11;
            r_iorqge_s <= 2'b11;
        end else begin
            r_wait_s   <= {r_wait_s[0], n_wait};
            r_iorqge_s <= {r_iorqge_s[0], n_iorqge};
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_a         <= '0;
            r_d_oe      <= 1'b0;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_wcnt      <= '0;
            r_to        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_claimed   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wr    <= req_wr;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_tick) begin
                        r_a     <= r_addr;
                        r_d_oe  <= r_wr;
                        r_state <= S_T1;
                    end
                end
                S_T1: begin
                    if (w_tick) begin
                        r_claimed <= ~r_iorqge_s[1];
                        r_iorq_n  <= 1'b0;
                        r_rd_n    <= r_wr;
                        r_wr_n    <= ~r_wr;
                        r_state   <= S_T2;
                    end
                end
                S_T2: begin
                    if (w_tick) begin
                        r_wcnt  <= '0;
                        r_to    <= 1'b0;
                        r_state <= S_TW;
                    end
                end
                S_TW: begin
                    if (w_tick) begin
                        if (r_wait_s[1]) begin
                            r_state <= S_T3;
                        end else if (r_wcnt < W_MAX) begin
                            r_wcnt <= r_wcnt + 8'd1;
                        end else begin
                            r_to    <= 1'b1;
                            r_state <= S_T3;
                        end
                    end
                end
                S_T3: begin
                    if (w_tick) begin
                        if (!r_wr) begin
                            r_rdata <= d;
                        end
                        r_timeout   <= r_to;
                        r_rsp_valid <= 1'b1;
                        r_iorq_n    <= 1'b1;
                        r_rd_n      <= 1'b1;
                        r_wr_n      <= 1'b1;
                        r_d_oe      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zxbus_io_master.sv
// Randomized bench for zxbus_io_master against a tick-level
// model of the IN/OUT cycle built from the bus cycle rules.
`timescale 1ns/1ps
module tb_zxbus_io_master;

    localparam int WMAX = 4;
    localparam int STEP = 7;
    localparam int MODN = 64;

    logic        clk32 = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_claimed;
    logic        rsp_timeout;
    logic        tclk;
    logic [15:0] a;
    wire  [7:0]  d;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic        n_m1;
    logic        n_mreq;
    logic        n_wait = 1'b1;
    logic        n_iorqge = 1'b1;

    logic        drv_force = 1'b0;
    logic [7:0]  drv_val = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_rdata = '0;
    bit          have_prev = 0;
    int unsigned last_rsp_tick = 0;

    int          ph = 0;
    int unsigned tick_cnt = 0;

    // The card answers reads by driving d while n_rd is low.
    assign d = (drv_force || !n_rd) ? drv_val : 8'hzz;

    zxbus_io_master #(
        .ACC_W    (6),
        .ACC_STEP (STEP),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk32       (clk32),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_claimed (rsp_claimed),
        .rsp_timeout (rsp_timeout),
        .tclk        (tclk),
        .a           (a),
        .d           (d),
        .n_iorq      (n_iorq),
        .n_rd        (n_rd),
        .n_wr        (n_wr),
        .n_m1        (n_m1),
        .n_mreq      (n_mreq),
        .n_wait      (n_wait),
        .n_iorqge    (n_iorqge)
    );

    always #5 clk32 = ~clk32;

    // Tick reference: a 3.5/32 fractional rate, 7 steps of 64.
    always @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0;
        end else begin
            if (ph + STEP >= MODN) tick_cnt <= tick_cnt + 1;
            ph <= (ph + STEP) % MODN;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input bit wr, input logic [15:0] addr,
                            input logic [7:0] wd, output bit ok);
        ok = 0;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk32);
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk32);
                #1;
                ok = 1;
            end else begin
                @(negedge clk32);
            end
        end
        req_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic do_txn(input bit wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] rv,
                          input bit claim, input int waits, input bit to);
        bit          ok;
        bit          done;
        int unsigned c_acc;
        int unsigned c_prev;
        int          exp_len;
        int          len;
        int          strobe_ticks;
        int          d_bad;
        int          overlap;
        exp_len      = to ? WMAX + 4 : waits + 4;
        len          = -1;
        strobe_ticks = 0;
        d_bad        = 0;
        overlap      = 0;
        done         = 0;
        n_iorqge     = claim ? 1'b0 : 1'b1;
        n_wait       = (to || waits > 0) ? 1'b0 : 1'b1;
        drv_val      = rv;
        send_req(wr, addr, wd, ok);
        if (!ok) return;
        chk("ready_low", 32'(req_ready), 0);
        c_acc  = tick_cnt;
        c_prev = c_acc;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(posedge clk32);
            #1;
            if (tick_cnt != c_prev) begin
                c_prev = tick_cnt;
                if (tick_cnt == c_acc + 1) begin
                    chk("addr_t1", 32'(a), 32'(addr));
                    if (wr) chk("wdata_t1", 32'(d), 32'(wd));
                end
                if (tick_cnt == c_acc + 2) begin
                    chk("iorq_t2", 32'(n_iorq), 0);
                    if (have_prev)
                        chk("b2b_gap", 32'(tick_cnt - last_rsp_tick >= 2), 1);
                end
                if (!n_iorq && !(wr ? n_wr : n_rd)) strobe_ticks++;
                if (!to && waits > 0 && tick_cnt == c_acc + 3 + waits)
                    n_wait = 1'b1;
            end
            if (!n_rd && !n_wr) overlap++;
            if (wr && !n_wr && d !== wd) d_bad++;
            if (rsp_valid) begin
                done = 1;
                len  = int'(tick_cnt - (c_acc + 1));
                last_rsp_tick = tick_cnt;
            end
        end
        chk("rsp_seen", 32'(done), 1);
        n_wait = 1'b1;
        if (!done) return;
        if (!wr) exp_rdata = rv;
        chk("cycle_ticks", 32'(len), 32'(exp_len));
        chk("strobe_ticks", 32'(strobe_ticks), 32'(exp_len - 1));
        chk("wdata_hold", 32'(d_bad), 0);
        chk("rd_wr_overlap", 32'(overlap), 0);
        chk("claimed", 32'(rsp_claimed), 32'(claim));
        chk("timeout", 32'(rsp_timeout), 32'(to));
        chk("rdata", 32'(rsp_rdata), 32'(exp_rdata));
        @(posedge clk32);
        #1;
        chk("rsp_pulse", 32'(rsp_valid), 0);
        chk("strobes_idle", 32'({n_iorq, n_rd, n_wr}), 32'h7);
        chk("ready_idle", 32'(req_ready), 1);
        have_prev = 1;
    endtask

    task automatic reset_mid();
        bit ok;
        bit in_t2;
        int rv_seen;
        in_t2    = 0;
        rv_seen  = 0;
        n_iorqge = 1'b0;
        n_wait   = 1'b0;
        send_req(1'b1, 16'hA55A, 8'hC3, ok);
        for (int i = 0; i < 200 && !in_t2; i++) begin
            @(posedge clk32);
            #1;
            if (!n_iorq) in_t2 = 1;
        end
        chk("reach_t2", 32'(in_t2), 1);
        #2;
        rst_n     = 1'b0;
        drv_force = 1'b1;
        drv_val   = 8'h5A;
        #1;
        chk("rst_strobes", 32'({n_iorq, n_rd, n_wr}), 32'h7);
        chk("rst_d_float", 32'(d), 32'h5A);
        chk("rst_addr", 32'(a), 0);
        chk("rst_ready", 32'(req_ready), 1);
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) rv_seen++;
            @(posedge clk32);
            #1;
        end
        chk("rst_no_rsp", 32'(rv_seen), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        drv_force = 1'b0;
        n_wait    = 1'b1;
        exp_rdata = '0;
        have_prev = 0;
        @(negedge clk32);
        rst_n = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          wr;
        bit          to;
        bit          claim;
        int          waits;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rv;
        #23;
        chk("reset_ready", 32'(req_ready), 1);
        chk("reset_bus", 32'({a, n_iorq, n_rd, n_wr, n_m1, n_mreq}), 32'h1F);
        chk("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_claimed, rsp_timeout}), 0);
        chk("reset_tclk", 32'(tclk), 0);
        @(negedge clk32);
        rst_n = 1'b1;

        do_txn(1'b1, 16'hFFFD, 8'hFE, 8'h00, 1'b1, 0, 1'b0);
        do_txn(1'b0, 16'h00BB, 8'h00, 8'h7E, 1'b1, 0, 1'b0);
        do_txn(1'b1, 16'h1234, 8'h55, 8'h00, 1'b1, 3, 1'b0);
        do_txn(1'b0, 16'h5678, 8'h00, 8'hA5, 1'b1, 0, 1'b1);
        do_txn(1'b0, 16'h00FE, 8'h00, 8'h3C, 1'b0, 1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 16'($urandom_range(0, 65535));
            wd    = 8'($urandom_range(0, 255));
            rv    = 8'($urandom_range(0, 255));
            claim = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 3);
            to    = ($urandom_range(0, 5) == 0);
            do_txn(wr, addr, wd, rv, claim, waits, to);
        end

        reset_mid();
        do_txn(1'b1, 16'h00FD, 8'h11, 8'h00, 1'b1, 0, 1'b0);
        do_txn(1'b0, 16'hBFFD, 8'h00, 8'h99, 1'b1, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
